qerv_ibus_prefetch: RTL and testbench
=====================================

# qerv_ibus_prefetch

Single-entry sequential instruction prefetcher between the core's instruction bus (`o_ibus_adr`/`o_ibus_cyc`/`i_ibus_rdt`/`i_ibus_ack` of `qerv_rf_top`) and the instruction memory Wishbone port. After every delivered fetch it speculatively reads the next word (address + 4) into a one-word buffer. A sequential fetch that hits the buffer is acknowledged one cycle after request instead of waiting a full memory round-trip. Control flow changes and `i_flush` discard the buffer.

## Interface
- `RESET_STRATEGY`, "MINI": "MINI" resets control and data registers. "NONE" leaves `buf_dat` and `o_ibus_rdt` unreset; control registers are always reset.
- `clk` in 1: clock. All logic is on the rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_ibus_adr` in 32: core fetch address. Bits [1:0] are ignored.
- `i_ibus_cyc` in 1: core fetch request. Held until ack; dropped the cycle after ack.
- `o_ibus_rdt` out 32: instruction word returned to the core.
- `o_ibus_ack` out 1: one-cycle response strobe to the core.
- `i_flush` in 1: one-cycle pulse that invalidates the buffer (fence.i, trap entry).
- `o_wb_adr` out 32: memory address. Always word-aligned, bits [1:0] = 0.
- `o_wb_cyc` out 1: memory request.
- `i_wb_rdt` in 32: memory read data.
- `i_wb_ack` in 1: memory ack. Valid only while `o_wb_cyc` is high.
- `o_hits` out 32: prefetch hit count. Present only when `QERV_PREFETCH_CNT_EN` is defined.
- `o_misses` out 32: prefetch miss count. Present only when `QERV_PREFETCH_CNT_EN` is defined.

## Operation
- Internal state:
  - `buf_valid`, `buf_adr[29:0]`, `buf_dat[31:0]`
  - `pf_adr[29:0]`: address of the prefetch in flight
  - `pf_claim`: the core is waiting on the in-flight prefetch
  - `pf_drop`: the in-flight prefetch result is discarded
- Word addresses are 30 bits. Increment is `adr[31:2] + 1` modulo 2^30, so 0xFFFFFFFC wraps to 0x00000000.

State machine with states IDLE, DEMAND, PREF and WAITPF:
- **IDLE** (`o_wb_cyc` = 0)
  - Hit: `i_ibus_cyc` and `buf_valid` and `buf_adr == i_ibus_adr[31:2]`.
    - Next cycle: `o_ibus_ack` = 1, `o_ibus_rdt` = `buf_dat`, `buf_valid` ← 0.
    - Start a prefetch of `buf_adr + 1` → PREF.
  - Miss: `i_ibus_cyc` and not hit → `buf_valid` ← 0, `o_wb_adr` ← core address → DEMAND.
- **DEMAND** (`o_wb_cyc` = 1)
  - On `i_wb_ack`: next cycle `o_ibus_ack` = 1 and `o_ibus_rdt` = `i_wb_rdt` (registered).
  - `o_wb_cyc` drops in the same edge.
  - Start a prefetch of demand address + 1 → PREF. `o_wb_cyc` is low for exactly one cycle between the two requests.
- **PREF** (`o_wb_cyc` = 1, `o_wb_adr` = `pf_adr`)
  - Core requests `pf_adr`: set `pf_claim`. On `i_wb_ack`, ack the core with `i_wb_rdt`, leave the buffer empty, and prefetch `pf_adr + 1` (stay in PREF).
  - Core requests any other address: set `pf_drop` → WAITPF.
  - Without a core request, on `i_wb_ack`: `buf_dat` ← `i_wb_rdt`, `buf_adr` ← `pf_adr`, `buf_valid` ← 1 (unless `pf_drop`) → IDLE.
- **WAITPF**
  - A Wishbone cycle is never aborted.
  - On `i_wb_ack`, discard the data and issue the core's address → DEMAND.
- **`i_flush`**
  - Clears `buf_valid`.
  - If in PREF with `pf_claim` = 0, sets `pf_drop`.
  - A flush in the same cycle as a hit lookup wins: the lookup is treated as a miss.
- **Simultaneous events**
  - New core request and `i_wb_ack` of an unclaimed prefetch in the same cycle: the buffer fills first, and the request is looked up against it in the next cycle.
  - At most one memory request is outstanding at any time.

## Timing
- Reset: after reset the block sits in IDLE.
  - `o_wb_cyc` = 0, `o_ibus_ack` = 0
  - `buf_valid` = 0, `pf_claim` = 0, `pf_drop` = 0
  - `o_wb_adr` = 0
  - `o_ibus_rdt` = 0 when `RESET_STRATEGY` = "MINI"
- Reset mid-transaction: `o_wb_cyc` drops the following cycle. A late `i_wb_ack` is ignored.
- Buffer hit: `o_ibus_ack` asserts 1 cycle after `i_ibus_cyc` is first sampled high.
- Miss from IDLE: `o_wb_cyc` asserts 1 cycle after request. `o_ibus_ack` asserts 1 cycle after `i_wb_ack`.
- Claimed in-flight prefetch: `o_ibus_ack` asserts 1 cycle after `i_wb_ack`.
- `o_ibus_ack` is never high for two consecutive cycles.

## Configuration
- `QERV_PREFETCH_CNT_EN` defined:
  - Adds `o_hits` and `o_misses`, both wrapping 32-bit counters reset to 0.
  - Hit = buffer hit or claimed prefetch. Miss = any DEMAND entry.
- `QERV_PREFETCH_CNT_EN` undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package `qerv_prefetch_pkg`:
  - state enum `pf_state_t` (IDLE, DEMAND, PREF, WAITPF)
  - localparam `WADR_W` = 30
- Sub-module `qerv_prefetch_buf`: buffer registers plus the address-compare hit logic. The FSM stays in the top module.

## Test plan
- Sequential fetches: 0x100, 0x104, 0x108 with 3-cycle memory latency. The first fetch misses; 0x104 and 0x108 each ack 1 cycle after request with the correct data.
- Branch mid-prefetch: request 0x200 while the prefetch of 0x104 is pending. The 0x104 data is dropped, `o_wb_adr` = 0x200 is issued after its ack, and the core receives the 0x200 word.
- Claim in flight: request 0x104 while the prefetch of 0x104 is pending. The core is acked 1 cycle after `i_wb_ack` with no second memory read.
- Wrap: fetch at 0xFFFFFFFC. The prefetch address is 0x00000000, and a fetch of 0x0 then hits.
- Flush: `i_flush` after the buffer fills with 0x104; the next request to 0x104 misses and re-reads memory.
- Reset mid-DEMAND: `o_wb_cyc` is 0 the next cycle, and a later `i_wb_ack` produces no `o_ibus_ack`.
- With `QERV_PREFETCH_CNT_EN` defined: after the sequential scenario, `o_hits` = 2 and `o_misses` = 1.

Source files
------------

// File: rtl/qerv_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// qerv_prefetch_pkg
// Shared types for the sequential instruction prefetcher: the word-address
// width, the controller state encoding and a modulo-2^30 word increment.
// -----------------------------------------------------------------------------
package qerv_prefetch_pkg;

    localparam int WADR_W = 30;

    typedef logic [WADR_W-1:0] wadr_t;

    typedef enum logic [1:0] {
        IDLE,    // no memory cycle open
        DEMAND,  // reading the word the core asked for
        PREF,    // speculative read of the next sequential word
        WAITPF   // core branched away; draining the stale prefetch
    } pf_state_t;

    // Next sequential word; 0xFFFFFFFC wraps to 0x00000000.
    function automatic wadr_t wadr_inc(input wadr_t a);
        return a + WADR_W'(1);
    endfunction

endpackage

// File: rtl/qerv_ibus_prefetch_if.sv
// -----------------------------------------------------------------------------
// qerv_ibus_prefetch_if
// Classic single-word read bus, used both between the core and the prefetcher
// and between the prefetcher and instruction memory.
//   adr : byte address (32)         cyc : request, held until ack
//   rdt : read data (32)            ack : one-cycle response strobe
// Modports: master issues adr/cyc, slave returns rdt/ack.
// -----------------------------------------------------------------------------
interface qerv_ibus_prefetch_if;
    logic [31:0] adr;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;

    modport master (output adr, output cyc, input  rdt, input  ack);
    modport slave  (input  adr, input  cyc, output rdt, output ack);
endinterface

// File: rtl/qerv_prefetch_buf.sv
// -----------------------------------------------------------------------------
// qerv_prefetch_buf
// One-word prefetch buffer and its address comparator.
// Ports:
//   clk, i_rst        clock, synchronous active-high reset
//   clr_i             invalidate the buffer (wins over fill_i)
//   fill_i            load fill_adr_i/fill_dat_i and mark valid
//   lookup_adr_i      word address the core is asking for
//   hit_o             buffer valid and holds lookup_adr_i
//   buf_adr_o/dat_o   stored word address and data
// RESET_STRATEGY "NONE" leaves the data word unreset.
// -----------------------------------------------------------------------------
module qerv_prefetch_buf
    import qerv_prefetch_pkg::*;
#(
    parameter RESET_STRATEGY = "MINI"
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        clr_i,
    input  logic        fill_i,
    input  wadr_t       fill_adr_i,
    input  logic [31:0] fill_dat_i,
    input  wadr_t       lookup_adr_i,
    output logic        hit_o,
    output wadr_t       buf_adr_o,
    output logic [31:0] buf_dat_o
);

    logic        valid_q;
    wadr_t       adr_q;
    logic [31:0] dat_q;

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking assignments here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            adr_q   <= '0;
        end else begin
            if (clr_i)
                valid_q <= 1'b0;
            else if (fill_i)
                valid_q <= 1'b1;
            if (fill_i)
                adr_q <= fill_adr_i;
        end
    end

    // NOTE: the data word is qualified by valid_q, so leaving it unreset is
    // safe and drops the reset net from 32 flops.
    if (RESET_STRATEGY == "NONE") begin : g_dat_noreset
        always_ff @(posedge clk) begin
            if (fill_i)
                dat_q <= fill_dat_i;
        end
    end else begin : g_dat_reset
        always_ff @(posedge clk) begin
            if (i_rst)
                dat_q <= '0;
            else if (fill_i)
                dat_q <= fill_dat_i;
        end
    end

    assign hit_o     = valid_q && (adr_q == lookup_adr_i);
    assign buf_adr_o = adr_q;
    assign buf_dat_o = dat_q;

endmodule

// File: rtl/qerv_ibus_prefetch.sv
// -----------------------------------------------------------------------------
// qerv_ibus_prefetch
// Single-entry sequential instruction prefetcher. After each word delivered to
// the core it reads the next word into a one-entry buffer so a sequential
// fetch can be acknowledged one cycle after request.
// Ports:
//   clk, i_rst     clock, synchronous active-high reset
//   ibus (slave)   core instruction bus: adr/cyc in, rdt/ack out
//   wb   (master)  instruction memory: adr/cyc out, rdt/ack in
//   i_flush        one-cycle pulse invalidating the buffer
//   o_hits/o_misses  32-bit wrapping counters, only when the macro
//                  QERV_PREFETCH_CNT_EN is defined
// RESET_STRATEGY "MINI" resets all registers; "NONE" leaves data words unreset.
// -----------------------------------------------------------------------------
module qerv_ibus_prefetch
    import qerv_prefetch_pkg::*;
#(
    parameter RESET_STRATEGY = "MINI"
) (
    input  logic                  clk,
    input  logic                  i_rst,
    qerv_ibus_prefetch_if.slave   ibus,
    qerv_ibus_prefetch_if.master  wb,
    input  logic                  i_flush
`ifdef QERV_PREFETCH_CNT_EN
    ,
    output logic [31:0]           o_hits,
    output logic [31:0]           o_misses
`endif
);

    pf_state_t   state_q, state_d;
    wadr_t       wb_adr_q, wb_adr_d;   // in PREF/WAITPF this is pf_adr
    logic        gap_q, gap_d;         // forces cyc low for one cycle after an ack
    logic        claim_q, claim_d;
    logic        drop_q, drop_d;
    logic        ack_q, ack_d;
    logic [31:0] rdt_q, rdt_d;

    logic        buf_clr, buf_fill, buf_hit;
    wadr_t       buf_adr;
    logic [31:0] buf_dat;
    logic        hit_evt, miss_evt;

    wadr_t core_wadr;
    logic  wb_cyc, wb_ack, core_req;
    logic  unused_adr_bits;

    assign core_wadr       = ibus.adr[31:2];
    assign unused_adr_bits = ^ibus.adr[1:0];
    assign wb_cyc          = (state_q != IDLE) && !gap_q;
    // Acks outside an open cycle (e.g. after a reset) are ignored.
    assign wb_ack          = wb.ack && wb_cyc;
    // The core still holds cyc during its ack cycle; that is not a new request.
    assign core_req        = ibus.cyc && !ack_q;

    qerv_prefetch_buf #(.RESET_STRATEGY(RESET_STRATEGY)) u_buf (
        .clk          (clk),
        .i_rst        (i_rst),
        .clr_i        (buf_clr),
        .fill_i       (buf_fill),
        .fill_adr_i   (wb_adr_q),
        .fill_dat_i   (wb.rdt),
        .lookup_adr_i (core_wadr),
        .hit_o        (buf_hit),
        .buf_adr_o    (buf_adr),
        .buf_dat_o    (buf_dat)
    );

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        wb_adr_d = wb_adr_q;
        gap_d    = 1'b0;
        claim_d  = claim_q;
        drop_d   = drop_q;
        ack_d    = 1'b0;
        rdt_d    = rdt_q;
        buf_clr  = i_flush;
        buf_fill = 1'b0;
        hit_evt  = 1'b0;
        miss_evt = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (core_req) begin
                    buf_clr = 1'b1;
                    // A flush in the lookup cycle turns a hit into a miss.
                    if (buf_hit && !i_flush) begin
                        ack_d    = 1'b1;
                        rdt_d    = buf_dat;
                        wb_adr_d = wadr_inc(buf_adr);
                        state_d  = PREF;
                        hit_evt  = 1'b1;
                    end else begin
                        wb_adr_d = core_wadr;
                        state_d  = DEMAND;
                        miss_evt = 1'b1;
                    end
                end
            end

            DEMAND: begin
                if (wb_ack) begin
                    ack_d    = 1'b1;
                    rdt_d    = wb.rdt;
                    wb_adr_d = wadr_inc(wb_adr_q);
                    gap_d    = 1'b1;
                    state_d  = PREF;
                end
            end

            PREF: begin
                if (wb_ack) begin
                    if (claim_q) begin
                        ack_d    = 1'b1;
                        rdt_d    = wb.rdt;
                        claim_d  = 1'b0;
                        wb_adr_d = wadr_inc(wb_adr_q);
                        gap_d    = 1'b1;
                        hit_evt  = 1'b1;
                    end else begin
                        // A request arriving now is looked up next cycle,
                        // against the freshly filled buffer.
                        buf_fill = !drop_q && !i_flush;
                        drop_d   = 1'b0;
                        state_d  = IDLE;
                    end
                end else if (!claim_q) begin
                    if (core_req) begin
                        if (core_wadr == wb_adr_q && !drop_q && !i_flush)
                            claim_d = 1'b1;
                        else begin
                            drop_d  = 1'b1;
                            state_d = WAITPF;
                        end
                    end else if (i_flush) begin
                        drop_d = 1'b1;
                    end
                end
            end

            WAITPF: begin
                // The stale read is allowed to complete, then the core's
                // address is fetched.
                if (wb_ack) begin
                    drop_d   = 1'b0;
                    wb_adr_d = core_wadr;
                    gap_d    = 1'b1;
                    state_d  = DEMAND;
                    miss_evt = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            wb_adr_q <= '0;
            gap_q    <= 1'b0;
            claim_q  <= 1'b0;
            drop_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wb_adr_q <= wb_adr_d;
            gap_q    <= gap_d;
            claim_q  <= claim_d;
            drop_q   <= drop_d;
            ack_q    <= ack_d;
        end
    end

    if (RESET_STRATEGY == "NONE") begin : g_rdt_noreset
        always_ff @(posedge clk) rdt_q <= rdt_d;
    end else begin : g_rdt_reset
        always_ff @(posedge clk) begin
            if (i_rst)
                rdt_q <= '0;
            else
                rdt_q <= rdt_d;
        end
    end

    assign ibus.ack = ack_q;
    assign ibus.rdt = rdt_q;
    assign wb.adr   = {wb_adr_q, 2'b00};
    assign wb.cyc   = wb_cyc;

`ifdef QERV_PREFETCH_CNT_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (hit_evt)
                hits_q <= hits_q + 32'd1;
            if (miss_evt)
                misses_q <= misses_q + 32'd1;
        end
    end

    assign o_hits   = hits_q;
    assign o_misses = misses_q;
`else
    logic unused_cnt_evt;
    assign unused_cnt_evt = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_qerv_ibus_prefetch.sv
// -----------------------------------------------------------------------------
// tb_qerv_ibus_prefetch
// Directed bench for qerv_ibus_prefetch. A 3-cycle memory model returns
// adr ^ 0xDEAD0000; fetches push the expected word and ack cycle into a
// scoreboard that a monitor drains whenever the core sees an ack.
// -----------------------------------------------------------------------------
module tb_qerv_ibus_prefetch;

    localparam int MEM_LAT = 3;

    logic clk = 1'b0;
    logic i_rst;
    logic i_flush;

    always #5 clk = ~clk;

    qerv_ibus_prefetch_if ibus_if ();
    qerv_ibus_prefetch_if wb_if ();

`ifdef QERV_PREFETCH_CNT_EN
    logic [31:0] hits, misses;
`endif

    qerv_ibus_prefetch dut (
        .clk      (clk),
        .i_rst    (i_rst),
        .ibus     (ibus_if),
        .wb       (wb_if),
        .i_flush  (i_flush)
`ifdef QERV_PREFETCH_CNT_EN
        ,
        .o_hits   (hits),
        .o_misses (misses)
`endif
    );

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        logic [31:0] adr;
        logic [31:0] rdt;
        int unsigned at;
    } exp_t;

    exp_t exp_q[$];
    int   ack_count = 0;
    logic prev_ack  = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ibus_if.ack === 1'b1) begin
                ack_count++;
                check("ack_not_back_to_back", 32'(prev_ack), 32'd0);
                check("ack_has_pending_request", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("rdt_%08h", e.adr), ibus_if.rdt, e.rdt);
                    check($sformatf("ack_cycle_%08h", e.adr), cyc_cnt, e.at);
                end
            end
            prev_ack = ibus_if.ack;
        end
    end

    // ---------------- memory model ----------------
    int unsigned mem_reads    = 0;
    logic [31:0] mem_last_adr = '0;
    logic        mem_stall    = 1'b0;
    int unsigned inject_req   = 0;
    int unsigned inject_done  = 0;
    int unsigned lat_cnt      = 0;

    initial begin
        wb_if.ack = 1'b0;
        wb_if.rdt = '0;
        forever begin
            @(posedge clk);
            #1;
            if (wb_if.ack) begin
                wb_if.ack = 1'b0;
            end else if (inject_req != inject_done) begin
                inject_done = inject_req;
                wb_if.ack   = 1'b1;
                wb_if.rdt   = 32'hBAD0_BAD0;
            end else if (wb_if.cyc && !mem_stall) begin
                lat_cnt++;
                if (lat_cnt == MEM_LAT) begin
                    lat_cnt      = 0;
                    wb_if.ack    = 1'b1;
                    wb_if.rdt    = wb_if.adr ^ 32'hDEAD_0000;
                    mem_reads++;
                    mem_last_adr = wb_if.adr;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; lat is request-to-ack in cycles.
    task automatic fetch(input logic [31:0] adr, input logic [31:0] exp_rdt, input int unsigned lat);
        int unsigned waited = 0;
        logic        acked  = 1'b0;
        exp_q.push_back('{adr: adr, rdt: exp_rdt, at: cyc_cnt + lat});
        ibus_if.adr = adr;
        ibus_if.cyc = 1'b1;
        while (!acked && waited < 40) begin
            @(negedge clk);
            waited++;
            if (ibus_if.ack === 1'b1)
                acked = 1'b1;
        end
        check($sformatf("fetch_%08h_acked", adr), 32'(acked), 32'd1);
        @(posedge clk);
        #1;
        ibus_if.cyc = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r0;
        int          acks0;

        i_rst       = 1'b1;
        i_flush     = 1'b0;
        ibus_if.adr = '0;
        ibus_if.cyc = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wb_cyc",  32'(wb_if.cyc),   32'd0);
        check("rst_ibus_ack", 32'(ibus_if.ack), 32'd0);
        check("rst_wb_adr",  wb_if.adr,        32'h0);
        check("rst_ibus_rdt", ibus_if.rdt,     32'h0);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        wait_cycles(1);

        // Sequential: one miss, then two one-cycle buffer hits.
        fetch(32'h0000_0100, 32'hDEAD_0100, 4);
        wait_cycles(6);
        check("seq_reads_after_fill", mem_reads, 32'd2);
        fetch(32'h0000_0104, 32'hDEAD_0104, 1);
        wait_cycles(6);
        fetch(32'h0000_0108, 32'hDEAD_0108, 1);
        wait_cycles(6);
        check("seq_reads_total", mem_reads, 32'd4);
`ifdef QERV_PREFETCH_CNT_EN
        check("cnt_hits",   hits,   32'd2);
        check("cnt_misses", misses, 32'd1);
`endif

        // Branch while the 0x104 prefetch is in flight.
        fetch(32'h0000_0100, 32'hDEAD_0100, 4);
        fetch(32'h0000_0200, 32'hDEAD_0200, 7);
        check("branch_last_wb_adr", mem_last_adr, 32'h0000_0200);
        wait_cycles(6);

        // Claim the in-flight prefetch: no second read of 0x104.
        r0 = mem_reads;
        fetch(32'h0000_0100, 32'hDEAD_0100, 4);
        fetch(32'h0000_0104, 32'hDEAD_0104, 3);
        check("claim_reads", mem_reads, r0 + 2);
        wait_cycles(6);

        // Wrap at the top of the address space.
        fetch(32'hFFFF_FFFC, 32'h2152_FFFC, 4);
        @(negedge clk);
        check("wrap_pf_cyc", 32'(wb_if.cyc), 32'd1);
        check("wrap_pf_adr", wb_if.adr,      32'h0);
        wait_cycles(6);
        fetch(32'h0000_0000, 32'hDEAD_0000, 1);
        wait_cycles(6);

        // Flush after the buffer holds 0x104: next fetch re-reads memory.
        fetch(32'h0000_0100, 32'hDEAD_0100, 4);
        wait_cycles(6);
        i_flush = 1'b1;
        wait_cycles(1);
        i_flush = 1'b0;
        r0 = mem_reads;
        fetch(32'h0000_0104, 32'hDEAD_0104, 4);
        check("flush_reread", mem_reads, r0 + 1);
        wait_cycles(6);

        // Reset in the middle of a demand read, then a late ack.
        mem_stall   = 1'b1;
        ibus_if.adr = 32'h0000_0300;
        ibus_if.cyc = 1'b1;
        wait_cycles(2);
        @(negedge clk);
        check("mid_demand_cyc", 32'(wb_if.cyc), 32'd1);
        check("mid_demand_adr", wb_if.adr,      32'h0000_0300);
        @(posedge clk);
        #1;
        i_rst       = 1'b1;
        ibus_if.cyc = 1'b0;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        @(negedge clk);
        check("midrst_wb_cyc",   32'(wb_if.cyc), 32'd0);
        check("midrst_wb_adr",   wb_if.adr,      32'h0);
        check("midrst_ibus_rdt", ibus_if.rdt,    32'h0);
        acks0 = ack_count;
        wait_cycles(1);
        inject_req++;
        wait_cycles(4);
        check("late_ack_ignored", 32'(ack_count), 32'(acks0));
        mem_stall = 1'b0;

        // Recovery after reset: buffer is empty, so this misses.
        fetch(32'h0000_0400, 32'hDEAD_0400, 4);
        wait_cycles(8);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
